// File: rtl/uart_param_rx_if.sv
// Receiver bundle: serial line in, decoded launch parameters and frame status out.
interface uart_param_rx_if;
  logic        rx_i;
  logic [19:0] corner_o;
  logic [31:0] speed_o;
  logic        start_o;
  logic        err_o;
  logic        busy_o;

  modport master (input rx_i, output corner_o, speed_o, start_o, err_o, busy_o);
  modport slave  (output rx_i, input corner_o, speed_o, start_o, err_o, busy_o);
endinterface

// File: rtl/uart_param_rx.sv
// 8N1 UART receiver plus 9-byte command-frame parser (header, 3-byte angle, 4-byte speed, XOR checksum).
// Optional FRAME_TIMEOUT_EN aborts a partial frame after 20 bit-times without a byte.
module uart_param_rx #(
  parameter int          CLK_FRE      = 27,
  parameter int          UART_FRE     = 9600,
  parameter int          PAYLOAD_BITS = 8,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  uart_param_rx_if.master bus
);

  localparam int BAUD_DIV = CLK_FRE * 1_000_000 / UART_FRE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam int BW       = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_st_e;
  typedef enum logic [1:0] {F_HDR, F_PAY, F_CHK} frm_st_e;

  logic                    rx_s1_q, rx_s2_q, rx_prev_q;
  bit_st_e                 bit_st_q;
  logic [CW-1:0]           cnt_q;
  logic [BW-1:0]           bits_q;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic                    byte_vld_q;
  logic                    frm_err_q;

  // Bit-level receiver: edge-triggered start, mid-bit sampling, early return after stop sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      bit_st_q   <= IDLE;
      cnt_q      <= '0;
      bits_q     <= '0;
      data_q     <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_s1_q    <= bus.rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      case (bit_st_q)
        IDLE: begin
          cnt_q  <= '0;
          bits_q <= '0;
          if (rx_prev_q && !rx_s2_q) bit_st_q <= START;
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            bit_st_q <= rx_s2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BAUD_LAST) begin
            cnt_q  <= '0;
            data_q <= {rx_s2_q, data_q[PAYLOAD_BITS-1:1]};
            if (bits_q == BITS_LAST) begin
              bits_q   <= '0;
              bit_st_q <= STOP;
            end else begin
              bits_q <= bits_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BAUD_LAST) begin
            cnt_q      <= '0;
            bit_st_q   <= IDLE;
            byte_vld_q <= rx_s2_q;
            frm_err_q  <= !rx_s2_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: bit_st_q <= IDLE;
      endcase
    end
  end

  logic [7:0] byte_dat;
  assign byte_dat = data_q[7:0];

  frm_st_e     frm_st_q;
  logic [55:0] pay_q;
  logic [7:0]  chk_q;
  logic [2:0]  pcnt_q;
  logic [19:0] corner_q;
  logic [31:0] speed_q;
  logic        start_q, err_q, busy_q;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(20 * BAUD_DIV + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(20 * BAUD_DIV - 1);
  logic [TW-1:0] to_q;
  logic          to_hit;
  assign to_hit = busy_q && (to_q == TO_LAST);
`endif

  // Frame parser: start/err are mutually exclusive branches, so they can never coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frm_st_q <= F_HDR;
      pay_q    <= '0;
      chk_q    <= '0;
      pcnt_q   <= '0;
      corner_q <= '0;
      speed_q  <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      if (!busy_q || byte_vld_q || to_hit) to_q <= '0;
      else                                 to_q <= to_q + 1'b1;
`endif
      if (frm_err_q) begin
        if (frm_st_q != F_HDR) begin
          err_q    <= 1'b1;
          busy_q   <= 1'b0;
          frm_st_q <= F_HDR;
        end
      end else if (byte_vld_q) begin
        case (frm_st_q)
          F_HDR: begin
            if (byte_dat == HDR_BYTE) begin
              frm_st_q <= F_PAY;
              busy_q   <= 1'b1;
              pcnt_q   <= '0;
              chk_q    <= '0;
            end
          end
          F_PAY: begin
            pay_q <= {pay_q[47:0], byte_dat};
            chk_q <= chk_q ^ byte_dat;
            if (pcnt_q == 3'd6) frm_st_q <= F_CHK;
            else                pcnt_q   <= pcnt_q + 1'b1;
          end
          F_CHK: begin
            frm_st_q <= F_HDR;
            busy_q   <= 1'b0;
            if (byte_dat == chk_q && pay_q[55:52] == 4'h0) begin
              corner_q <= pay_q[51:32];
              speed_q  <= pay_q[31:0];
              start_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: frm_st_q <= F_HDR;
        endcase
      end
`ifdef FRAME_TIMEOUT_EN
      else if (to_hit) begin
        err_q    <= 1'b1;
        busy_q   <= 1'b0;
        frm_st_q <= F_HDR;
      end
`endif
    end
  end

  assign bus.corner_o = corner_q;
  assign bus.speed_o  = speed_q;
  assign bus.start_o  = start_q;
  assign bus.err_o    = err_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_uart_param_rx.sv
// Scoreboard bench: stimulus pushes expected frame outcomes, a negedge monitor pops on START/ERR.
module tb_uart_param_rx;

  localparam int BAUD = 10;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_param_rx_if bus();

  uart_param_rx #(
    .CLK_FRE(27), .UART_FRE(2_700_000), .PAYLOAD_BITS(8), .HDR_BYTE(8'hA5)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    bit          is_start;
    logic [19:0] corner;
    logic [31:0] speed;
  } exp_t;

  exp_t        q[$];
  logic [19:0] m_corner;
  logic [31:0] m_speed;
  int          tests = 0;
  int          fails = 0;

  logic [7:0] f1 [9] = '{8'hA5, 8'h02, 8'h17, 8'h8D, 8'h03, 8'hFC, 8'h00, 8'h00, 8'h67};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: outcome of a frame derived directly from the frame rules.
  task automatic push_expect(input logic [7:0] f [9], input int bad_idx);
    exp_t       e;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i <= 7; i++) x ^= f[i];
    if (bad_idx >= 1 && bad_idx <= 8) begin
      e.is_start = 1'b0;
    end else begin
      e.is_start = (f[8] == x) && (f[1][7:4] == 4'h0);
    end
    if (e.is_start) begin
      m_corner = {f[1][3:0], f[2], f[3]};
      m_speed  = {f[4], f[5], f[6], f[7]};
    end
    e.corner = m_corner;
    e.speed  = m_speed;
    q.push_back(e);
  endtask

  task automatic bit_out(input logic v);
    bus.rx_i = v;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop_bit);
    bit_out(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] f [9], input int bad_idx);
    push_expect(f, bad_idx);
    for (int i = 0; i < 9; i++) begin
      send_byte(f[i], (i == bad_idx) ? 1'b0 : 1'b1);
      if (i == bad_idx) break;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    check(name, 64'(q.size()), 64'd0);
    repeat (2 * BAUD) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.start_o || bus.err_o)) begin
        if (bus.start_o && bus.err_o) check("start_err_same_cycle", 64'd1, 64'd0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got start=%0b err=%0b expected no event",
                   bus.start_o, bus.err_o);
        end else begin
          e = q.pop_front();
          check("event_is_start", 64'(bus.start_o), 64'(e.is_start));
          check("corner", 64'(bus.corner_o), 64'(e.corner));
          check("speed", 64'(bus.speed_o), 64'(e.speed));
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] f [9];
    logic [7:0] x;
    int         mode, bad, njunk;
    logic [7:0] jb;

    rst       = 1'b1;
    bus.rx_i  = 1'b1;
    m_corner  = '0;
    m_speed   = '0;
    repeat (3) @(negedge clk);
    check("rst_corner", 64'(bus.corner_o), 64'd0);
    check("rst_speed", 64'(bus.speed_o), 64'd0);
    check("rst_start", 64'(bus.start_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b0;
    repeat (2 * BAUD) @(negedge clk);

    // 1 good frame
    send_frame(f1, -1);
    wait_drain("drain_good");
    check("busy_after_frame", 64'(bus.busy_o), 64'd0);

    // 2 bad checksum
    f = f1; f[8] = 8'h68;
    send_frame(f, -1);
    wait_drain("drain_badchk");

    // 3 junk then good frame
    send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h12, 1'b1);
    check("busy_after_junk", 64'(bus.busy_o), 64'd0);
    f = f1; f[3] = 8'h8C; f[8] = 8'h66;
    send_frame(f, -1);
    wait_drain("drain_junk");

    // 4 angle out of range with correct checksum
    f = f1; f[1] = 8'h12; f[8] = 8'h77;
    send_frame(f, -1);
    wait_drain("drain_range");

    // 5 false start then good frame
    bus.rx_i = 1'b0;
    repeat (HALF - 2) @(negedge clk);
    bus.rx_i = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    check("busy_after_false_start", 64'(bus.busy_o), 64'd0);
    send_frame(f1, -1);
    wait_drain("drain_false_start");

    // 6 bad stop bit on S1, then recovery
    send_frame(f1, 6);
    wait_drain("drain_bad_stop");
    check("busy_after_abort", 64'(bus.busy_o), 64'd0);
    f = f1; f[7] = 8'h11; f[8] = 8'h76;
    send_frame(f, -1);
    wait_drain("drain_after_abort");

    // header value inside payload is data
    f = '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};
    send_frame(f, -1);
    wait_drain("drain_a5_payload");

    // 7 reset mid-frame
    for (int i = 0; i < 4; i++) send_byte(f1[i], 1'b1);
    check("busy_mid_frame", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_corner = '0;
    m_speed  = '0;
    check("midrst_corner", 64'(bus.corner_o), 64'd0);
    check("midrst_speed", 64'(bus.speed_o), 64'd0);
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    repeat (2 * BAUD) @(negedge clk);
    send_frame(f1, -1);
    wait_drain("drain_after_rst");

    // randomized frames with junk prefixes and assorted corruptions
    for (int n = 0; n < 16; n++) begin
      njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        send_byte(jb, 1'($urandom_range(0, 1)));
      end
      mode = $urandom_range(0, 3);
      f[0] = 8'hA5;
      for (int i = 1; i <= 7; i++) f[i] = 8'($urandom);
      f[1][7:4] = (mode == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
      x = 8'h00;
      for (int i = 1; i <= 7; i++) x ^= f[i];
      f[8] = (mode == 1) ? (x ^ 8'($urandom_range(1, 255))) : x;
      bad  = (mode == 3) ? $urandom_range(1, 8) : -1;
      send_frame(f, bad);
      wait_drain("drain_random");
    end

    // 8 partial frame followed by silence
`ifdef FRAME_TIMEOUT_EN
    f = f1; f[2] = 8'h00;
    push_expect(f, 1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int i = 0; i < 25 * BAUD && q.size() != 0; i++) @(negedge clk);
    check("timeout_drained", 64'(q.size()), 64'd0);
    check("timeout_busy", 64'(bus.busy_o), 64'd0);
`else
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (30 * BAUD) @(negedge clk);
    check("no_timeout_busy", 64'(bus.busy_o), 64'd1);
`endif

    repeat (4 * BAUD) @(negedge clk);
    check("final_queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
